// File: rtl/vdma_fb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vdma_fb_pkg
// Brief    : Shared types and helpers for the VDMA frame-buffer arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package vdma_fb_pkg;

  typedef enum logic [0:0] {
    FB_TRIPLE = 1'b0,
    FB_ROUND  = 1'b1
  } fb_mode_e;

  localparam int unsigned FB_MAX_BUF = 8;
  localparam int unsigned FB_MAX_RD  = 4;

  // First buffer after 'point' (ring order) that is neither held nor the
  // newest completed frame. If every other buffer is excluded the writer
  // stays where it is: its own buffer is never held or latest at that point.
  function automatic logic [2:0] fb_next_free(
    input logic [2:0]  point,
    input logic [7:0]  held_mask,
    input logic [2:0]  latest,
    input logic        latest_vld,
    input int unsigned num_buf
  );
    logic [2:0] sel;
    logic       found;
    logic [3:0] sum;
    logic [2:0] c;
    sel   = point;
    found = 1'b0;
    for (int unsigned k = 1; k < FB_MAX_BUF; k++) begin
      sum = {1'b0, point} + 4'(k);
      c   = 3'(32'(sum) % num_buf);
      if (!found && (k < num_buf) && !held_mask[c] &&
          !(latest_vld && (c == latest))) begin
        sel   = c;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  // Base-address lookup over the eight configurable buffer slots.
  function automatic logic [63:0] fb_base_addr(
    input logic [2:0]  idx,
    input logic [63:0] b0, input logic [63:0] b1,
    input logic [63:0] b2, input logic [63:0] b3,
    input logic [63:0] b4, input logic [63:0] b5,
    input logic [63:0] b6, input logic [63:0] b7
  );
    logic [63:0] r;
    case (idx)
      3'd0:    r = b0;
      3'd1:    r = b1;
      3'd2:    r = b2;
      3'd3:    r = b3;
      3'd4:    r = b4;
      3'd5:    r = b5;
      3'd6:    r = b6;
      default: r = b7;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vdma_fb_rd_slot.sv
`default_nettype none
// ============================================================================
// Module   : vdma_fb_rd_slot
// Brief    : One reader slot: held/fresh flags, buffer pointer, base address
//            and the repeat pulse.
// Revision : 1.0 - initial release
// ============================================================================
module vdma_fb_rd_slot import vdma_fb_pkg::*; #(
  parameter int unsigned      PTR_W    = 2,
  parameter int unsigned      ASIZE    = 29,
  parameter logic [ASIZE-1:0] RST_BASE = '0
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             take_i,        // reader starts a frame on latest
  input  logic             release_i,     // reader finished its frame
  input  logic             refresh_i,     // a new frame completed this cycle
  input  logic [PTR_W-1:0] take_point_i,
  input  logic [ASIZE-1:0] take_base_i,
  output logic             held_d_o,      // next-state hold, for writer's free test
  output logic [PTR_W-1:0] point_d_o,
  output logic [PTR_W-1:0] point_o,
  output logic [ASIZE-1:0] baseaddr_o,
  output logic             repeat_o
);

  logic             held_q, held_d;
  logic             fresh_q, fresh_d;
  logic [PTR_W-1:0] point_q, point_d;
  logic [ASIZE-1:0] base_q, base_d;
  logic             repeat_q, repeat_d;
  logic             fresh_now;

  // Next state: a same-cycle completion refreshes before the take, so a
  // forwarded frame never counts as a repeat. Take wins over release.
  always_comb begin
    fresh_now = refresh_i | fresh_q;
    held_d    = held_q;
    fresh_d   = fresh_now;
    point_d   = point_q;
    base_d    = base_q;
    repeat_d  = 1'b0;
    if (take_i) begin
      held_d   = 1'b1;
      fresh_d  = 1'b0;
      point_d  = take_point_i;
      base_d   = take_base_i;
      repeat_d = ~fresh_now;
    end else if (release_i) begin
      held_d = 1'b0;
    end
  end

  // Slot state registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      held_q   <= 1'b0;
      fresh_q  <= 1'b0;
      point_q  <= '0;
      base_q   <= RST_BASE;
      repeat_q <= 1'b0;
    end else begin
      held_q   <= held_d;
      fresh_q  <= fresh_d;
      point_q  <= point_d;
      base_q   <= base_d;
      repeat_q <= repeat_d;
    end
  end

  assign held_d_o   = held_d;
  assign point_d_o  = point_d;
  assign point_o    = point_q;
  assign baseaddr_o = base_q;
  assign repeat_o   = repeat_q;

endmodule
`default_nettype wire

// File: rtl/vdma_frame_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vdma_frame_buffer_arbiter
// Brief    : Frame-buffer pointer manager: one writer, NUM_RD readers over a
//            ring of NUM_BUF buffers, with N-buffering and drop/repeat flags.
// Revision : 1.0 - initial release
// ============================================================================
module vdma_frame_buffer_arbiter import vdma_fb_pkg::*; #(
  parameter int unsigned      NUM_BUF     = 4,
  parameter int unsigned      NUM_RD      = 2,
  parameter int unsigned      ASIZE       = 29,
  parameter string            MODE        = "TRIPLE",
  parameter logic [ASIZE-1:0] BASE_ADDR_0 = '0,
  parameter logic [ASIZE-1:0] BASE_ADDR_1 = '0,
  parameter logic [ASIZE-1:0] BASE_ADDR_2 = '0,
  parameter logic [ASIZE-1:0] BASE_ADDR_3 = '0,
  parameter logic [ASIZE-1:0] BASE_ADDR_4 = '0,
  parameter logic [ASIZE-1:0] BASE_ADDR_5 = '0,
  parameter logic [ASIZE-1:0] BASE_ADDR_6 = '0,
  parameter logic [ASIZE-1:0] BASE_ADDR_7 = '0,
  localparam int unsigned     PTR_W       = $clog2(NUM_BUF)
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    wr_fs,
  input  logic                    wr_fe,
  output logic [PTR_W-1:0]        wr_point,
  output logic [ASIZE-1:0]        wr_baseaddr,
  output logic                    wr_drop,
  input  logic [NUM_RD-1:0]       rd_fs,
  input  logic [NUM_RD-1:0]       rd_fe,
  output logic [NUM_RD*PTR_W-1:0] rd_point,
  output logic [NUM_RD*ASIZE-1:0] rd_baseaddr,
  output logic [NUM_RD-1:0]       rd_valid,
  output logic [NUM_RD-1:0]       rd_repeat
);

  localparam fb_mode_e MODE_E = (MODE == "ROUND") ? FB_ROUND : FB_TRIPLE;

  if ((NUM_BUF < 3) || (NUM_BUF > FB_MAX_BUF)) begin : g_chk_num_buf
    $fatal(1, "NUM_BUF must be in 3..8");
  end
  if ((NUM_RD < 1) || (NUM_RD > FB_MAX_RD)) begin : g_chk_num_rd
    $fatal(1, "NUM_RD must be in 1..4");
  end
  if ((MODE_E == FB_TRIPLE) && (NUM_BUF < NUM_RD + 2)) begin : g_chk_triple
    $fatal(1, "TRIPLE mode needs NUM_BUF >= NUM_RD+2");
  end

  function automatic logic [ASIZE-1:0] base_of(input logic [PTR_W-1:0] p);
    return ASIZE'(fb_base_addr(3'(p),
                               64'(BASE_ADDR_0), 64'(BASE_ADDR_1),
                               64'(BASE_ADDR_2), 64'(BASE_ADDR_3),
                               64'(BASE_ADDR_4), 64'(BASE_ADDR_5),
                               64'(BASE_ADDR_6), 64'(BASE_ADDR_7)));
  endfunction

  // Enable masks every event input in the same cycle.
  logic              wr_fs_en, wr_fe_en;
  logic [NUM_RD-1:0] rd_fs_en, rd_fe_en;
  assign wr_fs_en = enable & wr_fs;
  assign wr_fe_en = enable & wr_fe;
  assign rd_fs_en = {NUM_RD{enable}} & rd_fs;
  assign rd_fe_en = {NUM_RD{enable}} & rd_fe;

  logic              writing_q, writing_d;
  logic [PTR_W-1:0]  latest_q, latest_d;
  logic              latest_vld_q, latest_vld_d;
  logic              latest_taken_q, latest_taken_d;
  logic [PTR_W-1:0]  wr_point_q, wr_point_d;
  logic [ASIZE-1:0]  wr_baseaddr_q, wr_baseaddr_d;
  logic              wr_drop_q, wr_drop_d;
  logic              complete;
  logic [NUM_RD-1:0] rd_take;
  logic [ASIZE-1:0]  take_base;
  logic [NUM_RD-1:0]       slot_held_d;
  logic [NUM_RD*PTR_W-1:0] slot_point_d;
  logic [7:0]              held_mask;

  // Frame completion first, then reader takes see the updated latest
  // (forwarding); a take in the completing cycle suppresses the drop.
  always_comb begin
    complete       = wr_fe_en & writing_q;
    latest_d       = complete ? wr_point_q : latest_q;
    latest_vld_d   = latest_vld_q | complete;
    rd_take        = rd_fs_en & {NUM_RD{latest_vld_d}};
    latest_taken_d = (|rd_take) | (latest_taken_q & ~complete);
    wr_drop_d      = complete & latest_vld_q & ~latest_taken_q & ~(|rd_take);
    take_base      = base_of(latest_d);
  end

  // Buffers held by any reader after this cycle's takes and releases.
  always_comb begin
    held_mask = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (slot_held_d[i]) begin
        held_mask[3'(slot_point_d[i*PTR_W +: PTR_W])] = 1'b1;
      end
    end
  end

  // Writer buffer selection on frame start (also on abort).
  always_comb begin
    writing_d  = wr_fs_en | (writing_q & ~complete);
    wr_point_d = wr_point_q;
    if (wr_fs_en) begin
      if (MODE_E == FB_ROUND) begin
        wr_point_d = PTR_W'(fb_next_free(3'(wr_point_q), 8'h00, 3'd0, 1'b0,
                                         NUM_BUF));
      end else begin
        wr_point_d = PTR_W'(fb_next_free(3'(wr_point_q), held_mask,
                                         3'(latest_d), latest_vld_d, NUM_BUF));
      end
    end
    wr_baseaddr_d = base_of(wr_point_d);
  end

  // Writer-side state registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      writing_q      <= 1'b0;
      latest_q       <= '0;
      latest_vld_q   <= 1'b0;
      latest_taken_q <= 1'b0;
      wr_point_q     <= PTR_W'(NUM_BUF - 1);
      wr_baseaddr_q  <= base_of(PTR_W'(NUM_BUF - 1));
      wr_drop_q      <= 1'b0;
    end else begin
      writing_q      <= writing_d;
      latest_q       <= latest_d;
      latest_vld_q   <= latest_vld_d;
      latest_taken_q <= latest_taken_d;
      wr_point_q     <= wr_point_d;
      wr_baseaddr_q  <= wr_baseaddr_d;
      wr_drop_q      <= wr_drop_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_slot
    vdma_fb_rd_slot #(
      .PTR_W    (PTR_W),
      .ASIZE    (ASIZE),
      .RST_BASE (BASE_ADDR_0)
    ) u_slot (
      .clock        (clock),
      .rst_n        (rst_n),
      .take_i       (rd_take[g]),
      .release_i    (rd_fe_en[g]),
      .refresh_i    (complete),
      .take_point_i (latest_d),
      .take_base_i  (take_base),
      .held_d_o     (slot_held_d[g]),
      .point_d_o    (slot_point_d[g*PTR_W +: PTR_W]),
      .point_o      (rd_point[g*PTR_W +: PTR_W]),
      .baseaddr_o   (rd_baseaddr[g*ASIZE +: ASIZE]),
      .repeat_o     (rd_repeat[g])
    );
  end

  assign wr_point    = wr_point_q;
  assign wr_baseaddr = wr_baseaddr_q;
  assign wr_drop     = wr_drop_q;
  assign rd_valid    = {NUM_RD{latest_vld_q}};

endmodule
`default_nettype wire

// File: tb/tb_vdma_frame_buffer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdma_frame_buffer_arbiter
// Brief    : Self-checking bench: a TRIPLE and a ROUND instance driven by the
//            same stimulus and compared against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdma_frame_buffer_arbiter;

  localparam int NB = 4;
  localparam int NR = 2;
  localparam int AW = 29;
  localparam int PW = 2;

  logic          clock;
  logic          rst_n;
  logic          enable;
  logic          wr_fs, wr_fe;
  logic [NR-1:0] rd_fs, rd_fe;

  logic [PW-1:0]    wp_o   [2];
  logic [AW-1:0]    wba_o  [2];
  logic             drop_o [2];
  logic [NR*PW-1:0] rp_o   [2];
  logic [NR*AW-1:0] rba_o  [2];
  logic [NR-1:0]    rv_o   [2];
  logic [NR-1:0]    rep_o  [2];

  int n_checks = 0;
  int n_err    = 0;

  // Frame-level model: index 0 = TRIPLE instance, 1 = ROUND instance.
  int m_wp [2];
  int m_latest [2];
  bit m_lvld [2], m_writing [2], m_taken [2], m_drop [2];
  bit m_held [2][NR];
  bit m_fresh [2][NR];
  bit m_rep [2][NR];
  int m_rp [2][NR];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  vdma_frame_buffer_arbiter #(
    .NUM_BUF(NB), .NUM_RD(NR), .ASIZE(AW), .MODE("TRIPLE"),
    .BASE_ADDR_0(29'h0000040), .BASE_ADDR_1(29'h0100040),
    .BASE_ADDR_2(29'h0200040), .BASE_ADDR_3(29'h0300040)
  ) dut_tri (
    .clock(clock), .rst_n(rst_n), .enable(enable),
    .wr_fs(wr_fs), .wr_fe(wr_fe),
    .wr_point(wp_o[0]), .wr_baseaddr(wba_o[0]), .wr_drop(drop_o[0]),
    .rd_fs(rd_fs), .rd_fe(rd_fe),
    .rd_point(rp_o[0]), .rd_baseaddr(rba_o[0]),
    .rd_valid(rv_o[0]), .rd_repeat(rep_o[0])
  );

  vdma_frame_buffer_arbiter #(
    .NUM_BUF(NB), .NUM_RD(NR), .ASIZE(AW), .MODE("ROUND"),
    .BASE_ADDR_0(29'h0000040), .BASE_ADDR_1(29'h0100040),
    .BASE_ADDR_2(29'h0200040), .BASE_ADDR_3(29'h0300040)
  ) dut_rnd (
    .clock(clock), .rst_n(rst_n), .enable(enable),
    .wr_fs(wr_fs), .wr_fe(wr_fe),
    .wr_point(wp_o[1]), .wr_baseaddr(wba_o[1]), .wr_drop(drop_o[1]),
    .rd_fs(rd_fs), .rd_fe(rd_fe),
    .rd_point(rp_o[1]), .rd_baseaddr(rba_o[1]),
    .rd_valid(rv_o[1]), .rd_repeat(rep_o[1])
  );

  function automatic logic [AW-1:0] bexp(input int i);
    return AW'(32'h40 + i * 32'h0010_0000);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_wp[d] = NB - 1; m_latest[d] = 0;
      m_lvld[d] = 0; m_writing[d] = 0; m_taken[d] = 0; m_drop[d] = 0;
      for (int i = 0; i < NR; i++) begin
        m_held[d][i] = 0; m_fresh[d][i] = 0; m_rep[d][i] = 0; m_rp[d][i] = 0;
      end
    end
  endtask

  function automatic bit buf_free(input int d, input int c);
    if (m_lvld[d] && c == m_latest[d]) return 1'b0;
    for (int i = 0; i < NR; i++)
      if (m_held[d][i] && m_rp[d][i] == c) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(input int d, input bit en, input bit fs, input bit fe,
                            input logic [NR-1:0] rfs, input logic [NR-1:0] rfe);
    bit dropc, took, found;
    int start;
    m_drop[d] = 0;
    for (int i = 0; i < NR; i++) m_rep[d][i] = 0;
    if (!en) return;
    dropc = 0; took = 0;
    if (fe && m_writing[d]) begin
      dropc = m_lvld[d] && !m_taken[d];
      m_latest[d] = m_wp[d]; m_lvld[d] = 1; m_writing[d] = 0; m_taken[d] = 0;
      for (int i = 0; i < NR; i++) m_fresh[d][i] = 1;
    end
    for (int i = 0; i < NR; i++) begin
      if (rfs[i] && m_lvld[d]) begin
        m_rep[d][i] = !m_fresh[d][i];
        m_rp[d][i] = m_latest[d]; m_held[d][i] = 1; m_fresh[d][i] = 0;
        m_taken[d] = 1; took = 1;
      end else if (rfe[i]) begin
        m_held[d][i] = 0;
      end
    end
    m_drop[d] = dropc && !took;
    if (fs) begin
      m_writing[d] = 1;
      start = m_wp[d];
      if (d == 1) begin
        m_wp[d] = (start + 1) % NB;
      end else begin
        found = 0;
        for (int k = 1; k < NB; k++) begin
          if (!found && buf_free(d, (start + k) % NB)) begin
            m_wp[d] = (start + k) % NB; found = 1;
          end
        end
      end
    end
  endtask

  task automatic check_all(input int d);
    string n;
    n = (d == 0) ? "tri" : "rnd";
    chk({n, ".wr_point"}, 64'(wp_o[d]), 64'(m_wp[d]));
    chk({n, ".wr_baseaddr"}, 64'(wba_o[d]), 64'(bexp(m_wp[d])));
    chk({n, ".wr_drop"}, 64'(drop_o[d]), 64'(m_drop[d]));
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("%s.rd_point%0d", n, i), 64'(rp_o[d][i*PW +: PW]), 64'(m_rp[d][i]));
      chk($sformatf("%s.rd_baseaddr%0d", n, i), 64'(rba_o[d][i*AW +: AW]), 64'(bexp(m_rp[d][i])));
      chk($sformatf("%s.rd_valid%0d", n, i), 64'(rv_o[d][i]), 64'(m_lvld[d]));
      chk($sformatf("%s.rd_repeat%0d", n, i), 64'(rep_o[d][i]), 64'(m_rep[d][i]));
    end
  endtask

  task automatic cyc(input bit en, input bit fs, input bit fe,
                     input logic [NR-1:0] rfs, input logic [NR-1:0] rfe);
    enable = en; wr_fs = fs; wr_fe = fe; rd_fs = rfs; rd_fe = rfe;
    @(posedge clock);
    model_step(0, en, fs, fe, rfs, rfe);
    model_step(1, en, fs, fe, rfs, rfe);
    #1;
    check_all(0);
    check_all(1);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; wr_fs = 1'b0; wr_fe = 1'b0;
    rd_fs = '0; rd_fe = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all(0); check_all(1);
    rst_n = 1'b1;

    // Directed walk through the buffer-selection and flag rules.
    cyc(1, 1, 0, 2'b00, 2'b00); chk("dir.first_wp", 64'(wp_o[0]), 64'd0);
    cyc(1, 0, 1, 2'b00, 2'b00);
    cyc(1, 0, 0, 2'b11, 2'b00);
    chk("dir.first_rp0", 64'(rp_o[0][1:0]), 64'd0);
    chk("dir.first_valid", 64'(rv_o[0][0]), 64'd1);
    cyc(1, 0, 0, 2'b00, 2'b01);
    cyc(1, 1, 0, 2'b00, 2'b00);
    cyc(1, 0, 1, 2'b00, 2'b00);
    cyc(1, 0, 0, 2'b01, 2'b00);
    cyc(1, 1, 0, 2'b00, 2'b00);
    cyc(1, 0, 1, 2'b00, 2'b00);
    cyc(1, 1, 0, 2'b00, 2'b00); chk("dir.skip_latest", 64'(wp_o[0]), 64'd3);
    cyc(1, 0, 1, 2'b00, 2'b00); chk("dir.drop", 64'(drop_o[0]), 64'd1);
    cyc(1, 1, 0, 2'b00, 2'b00); chk("dir.skip_held", 64'(wp_o[0]), 64'd2);
    cyc(1, 0, 0, 2'b10, 2'b00); chk("dir.no_repeat", 64'(rep_o[0][1]), 64'd0);
    chk("dir.rp1", 64'(rp_o[0][3:2]), 64'd3);
    cyc(1, 0, 0, 2'b10, 2'b00); chk("dir.repeat", 64'(rep_o[0][1]), 64'd1);
    cyc(1, 0, 1, 2'b00, 2'b00); chk("dir.taken_no_drop", 64'(drop_o[0]), 64'd0);
    cyc(1, 1, 0, 2'b00, 2'b00); chk("dir.wrap_wp", 64'(wp_o[0]), 64'd0);
    cyc(1, 0, 1, 2'b01, 2'b00);
    chk("dir.fwd_rp0", 64'(rp_o[0][1:0]), 64'd0);
    chk("dir.fwd_rep", 64'(rep_o[0][0]), 64'd0);
    chk("dir.fwd_drop", 64'(drop_o[0]), 64'd0);
    cyc(0, 1, 0, 2'b00, 2'b00); chk("dir.enable_off", 64'(wp_o[0]), 64'd0);

    // Randomised traffic, including simultaneous events and enable gaps.
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 2) == 0,
          {$urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0},
          {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0});
    end

    // Reset in the middle of a write frame.
    cyc(1, 1, 0, 2'b00, 2'b00);
    rst_n = 1'b0;
    enable = 1'b1; wr_fe = 1'b1; rd_fs = 2'b11;
    #2;
    model_reset();
    check_all(0); check_all(1);
    @(posedge clock);
    #1;
    check_all(0); check_all(1);
    rst_n = 1'b1;
    cyc(0, 1, 0, 2'b00, 2'b00); chk("rst.enable_off", 64'(wp_o[0]), 64'd3);
    cyc(1, 0, 1, 2'b11, 2'b00); chk("rst.no_partial", 64'(rv_o[0]), 64'd0);

    for (int n = 0; n < 200; n++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 2) == 0,
          {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0},
          {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
